// File: rtl/pxs_cursor_pkg.sv
// Shared constants for the cursor overlay controller.
// Holds the pixel-stream layout (VS bit position), default raster size,
// cursor hot-spot constants shared with the overlay stage, FSM state
// encodings and a signed clamp helper used by the per-axis datapath.
package pxs_cursor_pkg;

    // Pixel stream: 24 bits of RGB in [23:0], VS at bit 24, HS at bit 25.
    localparam int PXS_STR_W = 26;
    localparam int PXS_VS    = 24;

    localparam int PXS_HRES      = 640;
    localparam int PXS_VRES      = 480;
    localparam int PXS_HOTSPOT_X = 16;
    localparam int PXS_HOTSPOT_Y = 16;

    localparam int REP_W = 8;

    // Button FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    function automatic logic signed [10:0] clamp_s11(
        input logic signed [10:0] v,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pxs_cursor_axis.sv
// One cursor coordinate register with load / step / hold.
// Ports:
//   px_clk, reset     clock and async active-high reset (position -> INIT)
//   load, load_val    load an absolute (clamped) position; wins over stepping
//   step_inc/step_dec move by STEP; both together means no motion
//   pos               registered position, always inside [MIN, MAX]
module pxs_cursor_axis
    import pxs_cursor_pkg::*;
#(
    parameter int MIN  = 0,
    parameter int MAX  = 639,
    parameter int INIT = 320,
    parameter int STEP = 1
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       load,
    input  logic [9:0] load_val,
    input  logic       step_inc,
    input  logic       step_dec,
    output logic [9:0] pos
);

    localparam logic signed [10:0] MIN_S  = 11'(MIN);
    localparam logic signed [10:0] MAX_S  = 11'(MAX);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    logic [9:0]         pos_q, pos_d;
    logic signed [10:0] cand;

    // 11-bit signed arithmetic lets a step below zero or past 1023 be
    // caught by the clamp instead of wrapping.
    always_comb begin
        cand = $signed({1'b0, pos_q});
        if (load)
            cand = $signed({1'b0, load_val});
        else if (step_inc && !step_dec)
            cand = cand + STEP_S;
        else if (step_dec && !step_inc)
            cand = cand - STEP_S;
        pos_d = 10'(clamp_s11(cand, MIN_S, MAX_S));
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) pos_q <= 10'(INIT);
        else       pos_q <= pos_d;
    end

    assign pos = pos_q;

endmodule

// File: rtl/pxs_cursor_ctrl.sv
// Cursor overlay sequencer.
// Owns cursor X/Y and the shape selector, committing every change on the
// frame tick (rising edge of VS) so the overlay never tears mid-frame.
// Ports:
//   px_clk, reset          pixel clock, async active-high reset
//   RGBStr_i               pixel stream, only the VS bit is snooped
//   btn_up/down/left/right debounced direction levels (auto-repeat)
//   btn_sel                rising edge toggles CurSel at the next tick
//   host_req/x/y, host_ack host load port; ack pulses after the applying tick
//   X, Y, CurSel           registered cursor state to the overlay
//   frame_upd              one-cycle pulse per frame tick
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no direction held; next held direction steps immediately
// HOLD    | direction held; rep_cnt counts frames to next repeat step
module pxs_cursor_ctrl
    import pxs_cursor_pkg::*;
#(
    parameter int HRES          = PXS_HRES,
    parameter int VRES          = PXS_VRES,
    parameter int HotSpotX      = PXS_HOTSPOT_X,
    parameter int HotSpotY      = PXS_HOTSPOT_Y,
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 4,
    parameter int X_INIT        = 320,
    parameter int Y_INIT        = 240
) (
    input  logic                 px_clk,
    input  logic                 reset,
    input  logic [PXS_STR_W-1:0] RGBStr_i,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_sel,
    input  logic                 host_req,
    input  logic [9:0]           host_x,
    input  logic [9:0]           host_y,
    output logic                 host_ack,
    output logic [9:0]           X,
    output logic [9:0]           Y,
    output logic                 CurSel,
    output logic                 frame_upd
);

    localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD - 1);

    logic             vs_q;
    logic             sel_q;
    logic             sel_pend_q, sel_pend_d;
    logic             cur_sel_q, cur_sel_d;
    logic             host_pend_q, host_pend_d;
    logic             host_blk_q, host_blk_d;
    logic             host_ack_q, host_ack_d;
    logic             frame_upd_q, frame_upd_d;
    logic [0:0]       state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;

    logic tick, sel_rise, host_valid, host_load, any_dir, step_now;
    logic unused_str;

    // Only VS is of interest; the reduction keeps the other bits referenced.
    assign unused_str = ^RGBStr_i;

    assign tick     = RGBStr_i[PXS_VS] & ~vs_q;
    assign sel_rise = btn_sel & ~sel_q;
    assign any_dir  = btn_up | btn_down | btn_left | btn_right;

    // host_blk_q stays set after an ack until req is seen low, so a
    // request held past its ack is not serviced twice.
    assign host_valid = host_pend_q | (host_req & ~host_ack_q & ~host_blk_q);
    assign host_load  = tick & host_valid;

    always_comb begin
        host_pend_d = host_valid & ~tick;
        host_blk_d  = host_blk_q;
        if (host_load)
            host_blk_d = 1'b1;
        else if (!host_req)
            host_blk_d = 1'b0;

        sel_pend_d = tick ? 1'b0 : (sel_pend_q | sel_rise);
        cur_sel_d  = cur_sel_q ^ (tick & (sel_pend_q | sel_rise));

        host_ack_d  = host_load;
        frame_upd_d = tick;
    end

    // The button FSM is frozen on a host-load frame: buttons are ignored
    // and the repeat timing carries on as if that frame never happened.
    always_comb begin
        state_d  = state_q;
        rep_d    = rep_q;
        step_now = 1'b0;
        if (tick && !host_valid) begin
            if (state_q == ST_IDLE) begin
                if (any_dir) begin
                    step_now = 1'b1;
                    rep_d    = REP_DLY;
                    state_d  = ST_HOLD;
                end
            end else begin
                if (!any_dir) begin
                    state_d = ST_IDLE;
                end else if (rep_q != '0) begin
                    rep_d = rep_q - 1'b1;
                end else begin
                    step_now = 1'b1;
                    rep_d    = REP_PER;
                end
            end
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            vs_q        <= 1'b1;
            sel_q       <= 1'b0;
            sel_pend_q  <= 1'b0;
            cur_sel_q   <= 1'b1;
            host_pend_q <= 1'b0;
            host_blk_q  <= 1'b0;
            host_ack_q  <= 1'b0;
            frame_upd_q <= 1'b0;
            state_q     <= ST_IDLE;
            rep_q       <= '0;
        end else begin
            vs_q        <= RGBStr_i[PXS_VS];
            sel_q       <= btn_sel;
            sel_pend_q  <= sel_pend_d;
            cur_sel_q   <= cur_sel_d;
            host_pend_q <= host_pend_d;
            host_blk_q  <= host_blk_d;
            host_ack_q  <= host_ack_d;
            frame_upd_q <= frame_upd_d;
            state_q     <= state_d;
            rep_q       <= rep_d;
        end
    end

    pxs_cursor_axis #(
        .MIN  (HotSpotX + 1),
        .MAX  (HRES - 2 - HotSpotX),
        .INIT (X_INIT),
        .STEP (STEP)
    ) u_axis_x (
        .px_clk   (px_clk),
        .reset    (reset),
        .load     (host_load),
        .load_val (host_x),
        .step_inc (step_now & btn_right),
        .step_dec (step_now & btn_left),
        .pos      (X)
    );

    // Y range is the full active height; the Y hot-spot only matters to
    // the overlay stage.
    pxs_cursor_axis #(
        .MIN  (0),
        .MAX  (VRES - 1),
        .INIT (Y_INIT),
        .STEP (STEP)
    ) u_axis_y (
        .px_clk   (px_clk),
        .reset    (reset),
        .load     (host_load),
        .load_val (host_y),
        .step_inc (step_now & btn_down),
        .step_dec (step_now & btn_up),
        .pos      (Y)
    );

    assign host_ack  = host_ack_q;
    assign CurSel    = cur_sel_q;
    assign frame_upd = frame_upd_q;

endmodule

// File: tb/tb_pxs_cursor_ctrl.sv
module tb_pxs_cursor_ctrl;
    import pxs_cursor_pkg::*;

    logic                 px_clk = 1'b0;
    logic                 reset;
    logic                 vs;
    logic [PXS_STR_W-1:0] rgb;
    logic                 btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic                 host_req;
    logic [9:0]           host_x, host_y;
    logic                 host_ack;
    logic [9:0]           X, Y;
    logic                 CurSel, frame_upd;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt = 0;
    int ack_cnt   = 0;
    int f0, a0;

    always #5 px_clk = ~px_clk;

    always_comb begin
        rgb = '0;
        rgb[PXS_VS] = vs;
    end

    pxs_cursor_ctrl dut (
        .px_clk    (px_clk),
        .reset     (reset),
        .RGBStr_i  (rgb),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_sel   (btn_sel),
        .host_req  (host_req),
        .host_x    (host_x),
        .host_y    (host_y),
        .host_ack  (host_ack),
        .X         (X),
        .Y         (Y),
        .CurSel    (CurSel),
        .frame_upd (frame_upd)
    );

    always @(negedge px_clk) begin
        if (frame_upd) frame_cnt++;
        if (host_ack)  ack_cnt++;
    end

    typedef struct {
        logic [3:0] btn;     // {up, down, left, right}
        int         frames;
        int         ex;
        int         ey;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One VS pulse: tick at the first posedge that sees vs=1.
    task automatic frame();
        @(negedge px_clk) vs = 1'b1;
        @(negedge px_clk) vs = 1'b0;
        repeat (2) @(negedge px_clk);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    initial begin
        vt[0]  = '{4'b0001, 30, 324, 240};  // right held: steps at 1,21,25,29
        vt[1]  = '{4'b0000, 1,  324, 240};
        vt[2]  = '{4'b0100, 1,  324, 241};  // down
        vt[3]  = '{4'b0000, 1,  324, 241};
        vt[4]  = '{4'b1101, 1,  325, 241};  // up+down cancel, right moves
        vt[5]  = '{4'b0000, 1,  325, 241};
        vt[6]  = '{4'b1010, 1,  324, 240};  // diagonal up-left
        vt[7]  = '{4'b0000, 1,  324, 240};
        vt[8]  = '{4'b0001, 21, 326, 240};  // steps at 1 and 21, rep now 3
        vt[9]  = '{4'b1000, 4,  326, 239};  // set changes in HOLD: 3 dec, then step up
        vt[10] = '{4'b0000, 1,  326, 239};

        reset = 1'b1; vs = 1'b0; btn_sel = 1'b0; host_req = 1'b0;
        host_x = '0; host_y = '0; set_btn(4'b0000);

        // Test 1: reset state and idle frames
        repeat (3) @(negedge px_clk);
        check("rst_X", int'(X), 320);
        check("rst_Y", int'(Y), 240);
        check("rst_CurSel", int'(CurSel), 1);
        check("rst_ack", int'(host_ack), 0);
        check("rst_frame_upd", int'(frame_upd), 0);
        reset = 1'b0;
        repeat (2) @(negedge px_clk);
        repeat (3) frame();
        check("idle_X", int'(X), 320);
        check("idle_Y", int'(Y), 240);
        check("idle_CurSel", int'(CurSel), 1);
        check("idle_frames", frame_cnt, 3);
        check("idle_acks", ack_cnt, 0);

        // Table-driven button vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge px_clk) set_btn(vt[i].btn);
            for (int f = 0; f < vt[i].frames; f++) frame();
            check($sformatf("vec%0d_X", i), int'(X), vt[i].ex);
            check($sformatf("vec%0d_Y", i), int'(Y), vt[i].ey);
        end

        // Test 3: host load with clamp, req held past ack
        a0 = ack_cnt;
        @(negedge px_clk) begin host_req = 1'b1; host_x = 10'd700; host_y = 10'd500; end
        frame();
        check("host_clamp_X", int'(X), 622);
        check("host_clamp_Y", int'(Y), 479);
        check("host_ack1", ack_cnt - a0, 1);
        repeat (3) frame();
        check("host_no_reack", ack_cnt - a0, 1);
        @(negedge px_clk) host_req = 1'b0;
        set_btn(4'b0001);
        frame();
        check("right_at_max", int'(X), 622);
        set_btn(4'b0000);
        frame();

        // Test 4: host wins over button on the same tick
        a0 = ack_cnt;
        @(negedge px_clk) begin
            host_req = 1'b1; host_x = 10'd100; host_y = 10'd100; set_btn(4'b1000);
        end
        frame();
        check("prio_X", int'(X), 100);
        check("prio_Y", int'(Y), 100);
        check("prio_ack", ack_cnt - a0, 1);
        @(negedge px_clk) host_req = 1'b0;
        frame();
        check("prio_next_Y", int'(Y), 99);
        set_btn(4'b0000);
        frame();

        // Test 5: clamps at the low edges, opposite buttons, sticky sel
        @(negedge px_clk) begin host_req = 1'b1; host_x = 10'd0; host_y = 10'd0; end
        frame();
        @(negedge px_clk) host_req = 1'b0;
        check("load_min_X", int'(X), 17);
        set_btn(4'b0010);
        frame();
        check("left_at_min", int'(X), 17);
        set_btn(4'b1000);
        frame();
        check("up_at_min", int'(Y), 0);
        set_btn(4'b0000);
        frame();
        set_btn(4'b0011);
        frame();
        check("left_right_X", int'(X), 17);
        set_btn(4'b0000);
        frame();
        @(negedge px_clk) btn_sel = 1'b1;
        @(negedge px_clk) btn_sel = 1'b0;
        repeat (2) @(negedge px_clk);
        check("sel_before_tick", int'(CurSel), 1);
        frame();
        check("sel_after_tick", int'(CurSel), 0);
        frame();
        check("sel_once", int'(CurSel), 0);

        // Test 6: reset with a pending request, VS high at release
        a0 = ack_cnt;
        @(negedge px_clk) begin host_req = 1'b1; host_x = 10'd200; host_y = 10'd300; end
        repeat (2) @(negedge px_clk);
        vs = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge px_clk);
        f0 = frame_cnt;
        reset = 1'b0;
        repeat (4) @(negedge px_clk);
        check("rst6_X", int'(X), 320);
        check("rst6_CurSel", int'(CurSel), 1);
        check("rst6_no_ack", ack_cnt - a0, 0);
        check("rst6_no_tick", frame_cnt - f0, 0);
        vs = 1'b0;
        repeat (2) @(negedge px_clk);
        frame();
        check("rst6_load_X", int'(X), 200);
        check("rst6_load_Y", int'(Y), 300);
        check("rst6_ack", ack_cnt - a0, 1);
        @(negedge px_clk) host_req = 1'b0;
        repeat (2) @(negedge px_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
